display_scan_capture: RTL and testbench
=======================================

// Module: display_scan_capture
// PURPOSE
//  Receive side of the 8-position multiplexed 7-segment bus (active-low anode/segment, one position per clk).
//  Samples led7_an/led7_seg and decodes each active position back to a 4-bit hex digit.
//  Publishes a coherent 4-digit snapshot once per complete scan and flags protocol violations.
//  Used as on-chip loopback checker / BIST monitor behind the display driver.
// PARAMETERS
//  STABLE_CNT  1   consecutive identical samples (an+seg) required before a commit; 1..15
//  TIMEOUT     64  cycles without anode change before stall_o asserts; >=2
// PORTS
//  clk_i            in   1  clock
//  rst_i            in   1  reset, asynchronous, active-high
//  led7_an_i        in   8  anode bus, active-low, bit p = position p
//  led7_seg_i       in   8  segments {a,b,c,d,e,f,g,dp}, active-low, a = bit7
//  clear_i          in   1  sync clear of sticky flags, capture mask, digits_valid_o
//  dig1000_o/dig100_o/dig10_o/dig1_o out 4 each  snapshot digits (positions 3/2/1/0)
//  digits_valid_o   out  1  level: at least one full frame since reset/clear
//  frame_o          out  1  1-cycle pulse: snapshot updated
//  code_err_o       out  1  sticky: unknown segment code on positions 0..3
//  blank_err_o      out  1  sticky: seg != 8'hFF on positions 4..7
//  an_err_o         out  1  sticky: more than one anode low
//  stall_o          out  1  level: anode unchanged for TIMEOUT cycles
// BEHAVIOUR
//  - Reset: all outputs 0; sample regs an=8'hFF, seg=8'hFF; capture mask, counters, shadow digits 0.
//  - Stage 1: register led7_an_i/led7_seg_i every cycle (an_q, seg_q).
//  - Stability: cnt = (an_q,seg_q)==previous ? sat(cnt+1) : 1. Commit once when cnt==STABLE_CNT;
//    no re-commit until the pair changes. STABLE_CNT=1: outputs update 2 clk after input edge.
//  - Commit, an_q==8'hFF: no action, no error.
//  - Commit, >1 zero bit in an_q: set an_err_o; nothing captured.
//  - Commit, single zero at p in 0..3: decode seg_q (codes 0..F = 03 9F 25 0D 99 49 41 1F 01 09 11 C1 63 85 61 71);
//    hit -> shadow[p]=nibble, mask[p]=1; miss (incl. 8'hFF) -> set code_err_o, mask[p] unchanged.
//  - Commit, p in 4..7: seg_q!=8'hFF -> set blank_err_o.
//  - Frame: on a valid commit to p=0 with mask==4'b1111 -> dig*_o <= shadow, frame_o=1, digits_valid_o=1,
//    mask <= 4'b0001 (current digit starts the next frame). Outputs change only at frame boundaries.
//  - Out-of-order/missing positions never block: mask just stays incomplete until all four seen.
//  - Stall: idle counter counts cycles an_q unchanged, saturates at TIMEOUT; stall_o = (count==TIMEOUT);
//    any an_q change zeroes counter and drops stall_o same cycle.
//  - clear_i: zeroes mask, digits_valid_o, stall counter, sticky flags; dig*_o retained.
//    Same-cycle error event + clear -> flag ends SET (events never lost). Same-cycle frame + clear ->
//    clear wins: no frame_o, mask 0, digits_valid_o 0.
//  - Reset mid-scan: everything returns to reset values; first frame after needs all four positions again.
// STRUCTURE
//  - display_pkg: SEG_BLANK=8'hFF, SEG_CODE[0:15] table, seg_encode()/seg_decode() functions
//    shared with the driver so both ends use one table.
//  - Sub-module seg7_decode: combinational 8-bit -> {hit, nibble[3:0]} LUT. Rest is flat in this module.
// TESTING
//  1. Driver-style scan, digits 4,3,2,1: FE/9F, FD/25, FB/0D, F7/99, EF..7F/FF, repeat -> at 2nd p=0 commit
//     frame_o pulse, dig1000..dig1 = 4,3,2,1, digits_valid_o=1, no error flags.
//  2. Position 1 seg=8'hAA for one scan -> code_err_o=1, no frame that scan; next clean scan -> frame_o, flag stays 1.
//  3. an=8'hFC -> an_err_o=1; an=8'hDF seg=8'h03 -> blank_err_o=1; clear_i -> both 0 next cycle.
//  4. an held 8'hFE for 64 cycles -> stall_o rises exactly at TIMEOUT; an->8'hFD -> stall_o=0 same cycle it is seen.
//  5. Reset after positions 0,1 captured -> all outputs 0; next frame_o only after full 0..3 + return to 0.
//  6. STABLE_CNT=3, 1- and 2-cycle glitch to seg=8'h01 on position 2 -> ignored, dig100_o keeps 2.

Source files
------------

// File: rtl/display_pkg.sv
// Shared 7-segment definitions used by both the display driver and the
// scan capture monitor, so both ends of the bus agree on one code table.
package display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_IDLE   = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp} patterns for hex digits 0..F
  localparam logic [7:0] SEG_CODE [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } seg_dec_t;

  // What a committed (anode, segment) sample turned out to be
  typedef enum logic [2:0] {
    COMMIT_NONE,
    COMMIT_IDLE,
    COMMIT_MULTI,
    COMMIT_DIGIT,
    COMMIT_BLANK
  } commit_kind_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
    return SEG_CODE[nibble];
  endfunction

  function automatic seg_dec_t seg_decode(input logic [7:0] seg);
    seg_dec_t dec;
    dec.hit    = 1'b0;
    dec.nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        dec.hit    = 1'b1;
        dec.nibble = 4'(i);
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup from an active-low segment pattern back to its hex
// digit; hit is low for any pattern that is not one of the sixteen codes.
module seg7_decode
  import display_pkg::*;
(
  input  logic [7:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  seg_dec_t dec;

  // Table lookup shared with the driver's encoder
  always_comb begin
    dec    = seg_decode(seg);
    hit    = dec.hit;
    nibble = dec.nibble;
  end

endmodule

// File: rtl/display_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: samples anode/segment
// lines, rebuilds a 4-digit snapshot once per complete scan and raises
// sticky flags for protocol violations plus a stall indicator.
module display_scan_capture
  import display_pkg::*;
#(
  parameter int STABLE_CNT = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] led7_an_i,
  input  logic [7:0] led7_seg_i,
  input  logic       clear_i,
  output logic [3:0] dig1000_o,
  output logic [3:0] dig100_o,
  output logic [3:0] dig10_o,
  output logic [3:0] dig1_o,
  output logic       digits_valid_o,
  output logic       frame_o,
  output logic       code_err_o,
  output logic       blank_err_o,
  output logic       an_err_o,
  output logic       stall_o
);

  localparam int               IDLE_W        = $clog2(TIMEOUT + 1);
  localparam logic [3:0]       STABLE_TARGET = 4'(STABLE_CNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX     = IDLE_W'(TIMEOUT);

  logic [7:0]        an_q, seg_q, an_p, seg_p;
  logic [3:0]        stab_cnt, stab_next;
  logic              pair_same, commit;
  logic [7:0]        low_bits;
  logic              multi_low;
  logic [2:0]        pos;
  commit_kind_t      kind;
  logic              dec_hit;
  logic [3:0]        dec_nibble;
  logic              digit_ok, code_evt, blank_evt, an_evt, frame_evt;
  logic [3:0]        mask, mask_next;
  logic [3:0][3:0]   shadow;
  logic [IDLE_W-1:0] idle_cnt, idle_next;

  seg7_decode u_seg7_decode (
    .seg    (seg_q),
    .hit    (dec_hit),
    .nibble (dec_nibble)
  );

  assign stall_o = (idle_cnt == IDLE_MAX);

  // Run length of the sampled pair; a commit fires exactly once per stable run
  always_comb begin
    pair_same = (an_q == an_p) && (seg_q == seg_p);
    if (!pair_same)
      stab_next = 4'd1;
    else if (stab_cnt == STABLE_TARGET)
      stab_next = stab_cnt;
    else
      stab_next = stab_cnt + 4'd1;
    commit = (stab_next == STABLE_TARGET) && !(pair_same && (stab_cnt == STABLE_TARGET));
  end

  // Classify a committed sample by how many anodes are low and which one
  always_comb begin
    low_bits  = ~an_q;
    multi_low = (low_bits & (low_bits - 8'd1)) != 8'd0;
    pos       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (low_bits[i]) pos = 3'(i);
    end
    kind = COMMIT_NONE;
    if (commit) begin
      if (an_q == AN_IDLE)
        kind = COMMIT_IDLE;
      else if (multi_low)
        kind = COMMIT_MULTI;
      else if (!pos[2])
        kind = COMMIT_DIGIT;
      else
        kind = COMMIT_BLANK;
    end
  end

  // Error events, frame detection, capture mask and idle counter next-state
  always_comb begin
    digit_ok  = (kind == COMMIT_DIGIT) && dec_hit;
    code_evt  = (kind == COMMIT_DIGIT) && !dec_hit;
    blank_evt = (kind == COMMIT_BLANK) && (seg_q != SEG_BLANK);
    an_evt    = (kind == COMMIT_MULTI);
    frame_evt = digit_ok && (pos == 3'd0) && (mask == 4'hF) && !clear_i;
    mask_next = mask;
    if (clear_i)
      mask_next = 4'h0;
    else if (frame_evt)
      mask_next = 4'b0001;
    else if (digit_ok)
      mask_next = mask | (4'b0001 << pos[1:0]);
    if ((led7_an_i != an_q) || clear_i)
      idle_next = '0;
    else if (idle_cnt != IDLE_MAX)
      idle_next = idle_cnt + 1'b1;
    else
      idle_next = idle_cnt;
  end

  // Sampling pipeline, capture state, snapshot outputs and sticky flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      an_q           <= AN_IDLE;
      seg_q          <= SEG_BLANK;
      an_p           <= AN_IDLE;
      seg_p          <= SEG_BLANK;
      stab_cnt       <= 4'd0;
      mask           <= 4'h0;
      shadow         <= '0;
      idle_cnt       <= '0;
      dig1000_o      <= 4'h0;
      dig100_o       <= 4'h0;
      dig10_o        <= 4'h0;
      dig1_o         <= 4'h0;
      digits_valid_o <= 1'b0;
      frame_o        <= 1'b0;
      code_err_o     <= 1'b0;
      blank_err_o    <= 1'b0;
      an_err_o       <= 1'b0;
    end else begin
      an_q     <= led7_an_i;
      seg_q    <= led7_seg_i;
      an_p     <= an_q;
      seg_p    <= seg_q;
      stab_cnt <= stab_next;
      mask     <= mask_next;
      idle_cnt <= idle_next;
      frame_o  <= frame_evt;
      if (digit_ok)
        shadow[pos[1:0]] <= dec_nibble;
      if (frame_evt) begin
        dig1000_o <= shadow[3];
        dig100_o  <= shadow[2];
        dig10_o   <= shadow[1];
        dig1_o    <= shadow[0];
      end
      if (clear_i)
        digits_valid_o <= 1'b0;
      else if (frame_evt)
        digits_valid_o <= 1'b1;
      code_err_o  <= (code_err_o  & ~clear_i) | code_evt;
      blank_err_o <= (blank_err_o & ~clear_i) | blank_evt;
      an_err_o    <= (an_err_o    & ~clear_i) | an_evt;
    end
  end

endmodule

// File: tb/tb_display_scan_capture.sv
// Self-checking bench for display_scan_capture: directed vector table,
// hand-written multi-cycle sequences and randomized traffic checked
// every cycle against a behavioural model of the receive rules.
module tb_display_scan_capture;

  localparam int STABLE  = 1;
  localparam int TIMEOUT = 64;

  localparam logic [7:0] TB_CODES [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        clr;
    logic [15:0] dig;
    logic [4:0]  flags;
  } vec_t;

  logic       clk_i, rst_i, clear_i;
  logic [7:0] led7_an_i, led7_seg_i;
  logic [3:0] dig1000_o, dig100_o, dig10_o, dig1_o;
  logic       digits_valid_o, frame_o, code_err_o, blank_err_o, an_err_o, stall_o;
  logic [3:0] d3_dig1000, d3_dig100, d3_dig10, d3_dig1;
  logic       d3_valid, d3_frame, d3_code, d3_blank, d3_an, d3_stall;

  int checks = 0;
  int errors = 0;
  int f1_cnt = 0;
  int f3_cnt = 0;
  vec_t rows [36];

  // behavioural model state
  logic [7:0] m_an, m_seg, l_an, l_seg;
  int         m_run, m_cyc, m_since;
  logic [3:0] m_seen;
  logic [3:0] m_shadow [4];
  logic [3:0] m_dig [4];
  logic       m_valid, m_frame, m_code, m_blank, m_anerr;

  display_scan_capture #(.STABLE_CNT(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .led7_an_i(led7_an_i), .led7_seg_i(led7_seg_i),
    .clear_i(clear_i), .dig1000_o(dig1000_o), .dig100_o(dig100_o), .dig10_o(dig10_o),
    .dig1_o(dig1_o), .digits_valid_o(digits_valid_o), .frame_o(frame_o),
    .code_err_o(code_err_o), .blank_err_o(blank_err_o), .an_err_o(an_err_o),
    .stall_o(stall_o)
  );

  display_scan_capture #(.STABLE_CNT(3), .TIMEOUT(TIMEOUT)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .led7_an_i(led7_an_i), .led7_seg_i(led7_seg_i),
    .clear_i(clear_i), .dig1000_o(d3_dig1000), .dig100_o(d3_dig100), .dig10_o(d3_dig10),
    .dig1_o(d3_dig1), .digits_valid_o(d3_valid), .frame_o(d3_frame),
    .code_err_o(d3_code), .blank_err_o(d3_blank), .an_err_o(d3_an),
    .stall_o(d3_stall)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int tbDecode(input logic [7:0] s);
    int r = -1;
    for (int i = 0; i < 16; i++) if (TB_CODES[i] == s) r = i;
    return r;
  endfunction

  // Reference model: applies the receive rules to what is on the bus each edge
  always @(posedge clk_i or posedge rst_i) begin : mdl
    int p, d;
    logic cm;
    if (rst_i) begin
      m_an = 8'hFF; m_seg = 8'hFF; l_an = 8'hFF; l_seg = 8'hFF;
      m_run = 0; m_cyc = 0; m_since = 0; m_seen = 4'h0;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'h0; m_dig[i] = 4'h0; end
      m_valid = 0; m_frame = 0; m_code = 0; m_blank = 0; m_anerr = 0;
    end else begin
      m_frame = 0;
      if (m_an == l_an && m_seg == l_seg) m_run++; else m_run = 1;
      cm = (m_run == STABLE);
      if (clear_i) begin m_code = 0; m_blank = 0; m_anerr = 0; end
      if (cm && m_an != 8'hFF) begin
        if ($countones(~m_an) > 1) m_anerr = 1;
        else begin
          p = 0;
          for (int i = 0; i < 8; i++) if (!m_an[i]) p = i;
          if (p < 4) begin
            d = tbDecode(m_seg);
            if (d < 0) m_code = 1;
            else begin
              if (p == 0 && m_seen == 4'hF && !clear_i) begin
                for (int i = 0; i < 4; i++) m_dig[i] = m_shadow[i];
                m_frame = 1; m_valid = 1; m_seen = 4'h0;
              end
              m_shadow[p] = 4'(d);
              m_seen[p] = 1'b1;
            end
          end else if (m_seg != 8'hFF) m_blank = 1;
        end
      end
      if (clear_i) begin m_seen = 4'h0; m_valid = 0; end
      m_cyc++;
      if (led7_an_i != m_an || clear_i) m_since = m_cyc;
      l_an = m_an; l_seg = m_seg;
      m_an = led7_an_i; m_seg = led7_seg_i;
    end
  end

  function automatic logic [31:0] actVec();
    return {10'b0, dig1000_o, dig100_o, dig10_o, dig1_o, digits_valid_o, frame_o,
            code_err_o, blank_err_o, an_err_o, stall_o};
  endfunction

  function automatic logic [31:0] mdlVec();
    logic st = (m_cyc - m_since) >= TIMEOUT;
    return {10'b0, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_frame,
            m_code, m_blank, m_anerr, st};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [7:0] seg, input logic clr);
    led7_an_i  = an;
    led7_seg_i = seg;
    clear_i    = clr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    if (frame_o) f1_cnt++;
    if (d3_frame) f3_cnt++;
    checkOutput("model", actVec(), mdlVec());
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    applyStimulus(an, seg, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    int b1, b3;
    rows[0]  = '{8'hFE, 8'h9F, 1'b0, 16'h0000, 5'b00000};
    rows[1]  = '{8'hFD, 8'h25, 1'b0, 16'h0000, 5'b00000};
    rows[2]  = '{8'hFB, 8'h0D, 1'b0, 16'h0000, 5'b00000};
    rows[3]  = '{8'hF7, 8'h99, 1'b0, 16'h0000, 5'b00000};
    rows[4]  = '{8'hEF, 8'hFF, 1'b0, 16'h0000, 5'b00000};
    rows[5]  = '{8'hDF, 8'hFF, 1'b0, 16'h0000, 5'b00000};
    rows[6]  = '{8'hBF, 8'hFF, 1'b0, 16'h0000, 5'b00000};
    rows[7]  = '{8'h7F, 8'hFF, 1'b0, 16'h0000, 5'b00000};
    rows[8]  = '{8'hFE, 8'h9F, 1'b0, 16'h4321, 5'b11000};
    rows[9]  = '{8'hFD, 8'h25, 1'b0, 16'h4321, 5'b10000};
    rows[10] = '{8'hFB, 8'h0D, 1'b0, 16'h4321, 5'b10000};
    rows[11] = '{8'hF7, 8'h99, 1'b0, 16'h4321, 5'b10000};
    rows[12] = '{8'hFE, 8'h9F, 1'b0, 16'h4321, 5'b11000};
    rows[13] = '{8'hFD, 8'hAA, 1'b0, 16'h4321, 5'b10100};
    rows[14] = '{8'hFB, 8'h0D, 1'b0, 16'h4321, 5'b10100};
    rows[15] = '{8'hF7, 8'h99, 1'b0, 16'h4321, 5'b10100};
    rows[16] = '{8'hFE, 8'h9F, 1'b0, 16'h4321, 5'b10100};
    rows[17] = '{8'hFD, 8'h49, 1'b0, 16'h4321, 5'b10100};
    rows[18] = '{8'hFB, 8'h0D, 1'b0, 16'h4321, 5'b10100};
    rows[19] = '{8'hF7, 8'h99, 1'b0, 16'h4321, 5'b10100};
    rows[20] = '{8'hFE, 8'h9F, 1'b0, 16'h4351, 5'b11100};
    rows[21] = '{8'hFC, 8'h9F, 1'b0, 16'h4351, 5'b10101};
    rows[22] = '{8'hDF, 8'h03, 1'b0, 16'h4351, 5'b10111};
    rows[23] = '{8'hDF, 8'h03, 1'b1, 16'h4351, 5'b00000};
    rows[24] = '{8'hFE, 8'h03, 1'b0, 16'h4351, 5'b00000};
    rows[25] = '{8'hFD, 8'hAA, 1'b1, 16'h4351, 5'b00100};
    rows[26] = '{8'hFD, 8'h25, 1'b0, 16'h4351, 5'b00100};
    rows[27] = '{8'hFB, 8'h0D, 1'b0, 16'h4351, 5'b00100};
    rows[28] = '{8'hF7, 8'h99, 1'b0, 16'h4351, 5'b00100};
    rows[29] = '{8'hFE, 8'h9F, 1'b0, 16'h4351, 5'b00100};
    rows[30] = '{8'hFE, 8'h03, 1'b1, 16'h4351, 5'b00000};
    rows[31] = '{8'hFD, 8'h25, 1'b0, 16'h4351, 5'b00000};
    rows[32] = '{8'hFB, 8'h0D, 1'b0, 16'h4351, 5'b00000};
    rows[33] = '{8'hF7, 8'h99, 1'b0, 16'h4351, 5'b00000};
    rows[34] = '{8'hFE, 8'h9F, 1'b0, 16'h4351, 5'b00000};
    rows[35] = '{8'hFE, 8'h25, 1'b0, 16'h4321, 5'b11000};

    rst_i = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset", actVec(), 32'h0);
    checkOutput("reset_d3", 32'({d3_dig1000, d3_dig100, d3_dig10, d3_dig1, d3_valid,
                                 d3_frame, d3_code, d3_blank, d3_an, d3_stall}), 32'h0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 36; i++) begin
      applyStimulus(rows[i].an, rows[i].seg, 1'b0);
      tick();
      clear_i = rows[i].clr;
      tick();
      checkOutput($sformatf("row%0d", i),
                  32'({dig1000_o, dig100_o, dig10_o, dig1_o, digits_valid_o, frame_o,
                       code_err_o, blank_err_o, an_err_o}),
                  32'({rows[i].dig, rows[i].flags}));
    end

    $display("[TB] stall timeout");
    applyStimulus(8'hFD, 8'h25, 1'b0);
    tick();
    repeat (TIMEOUT - 1) tick();
    checkOutput("stall_before", 32'(stall_o), 32'd0);
    tick();
    checkOutput("stall_at_timeout", 32'(stall_o), 32'd1);
    applyStimulus(8'hFB, 8'h0D, 1'b0);
    tick();
    checkOutput("stall_drop", 32'(stall_o), 32'd0);

    $display("[TB] reset mid-scan");
    hold(8'hFE, 8'h03, 2);
    hold(8'hFD, 8'h9F, 2);
    #2 rst_i = 1'b1;
    #1 checkOutput("rst_mid", actVec(), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    b1 = f1_cnt;
    hold(8'hFB, 8'h0D, 2);
    hold(8'hF7, 8'h99, 2);
    hold(8'hFE, 8'h03, 2);
    checkOutput("no_frame_after_rst", 32'(f1_cnt - b1), 32'd0);
    hold(8'hFD, 8'h9F, 2);
    hold(8'hFB, 8'h0D, 2);
    hold(8'hF7, 8'h99, 2);
    hold(8'hFE, 8'h03, 2);
    checkOutput("frame_after_rst", 32'(f1_cnt - b1), 32'd1);
    checkOutput("dig_after_rst", 32'({dig1000_o, dig100_o, dig10_o, dig1_o}), 32'h4310);

    $display("[TB] glitch filter with STABLE_CNT=3");
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    b3 = f3_cnt;
    hold(8'hFE, 8'h9F, 4);
    hold(8'hFD, 8'h25, 4);
    hold(8'hFB, 8'h25, 4);
    hold(8'hF7, 8'h99, 4);
    hold(8'hFE, 8'h9F, 4);
    checkOutput("d3_frame1", 32'(f3_cnt - b3), 32'd1);
    checkOutput("d3_dig1", 32'({d3_dig1000, d3_dig100, d3_dig10, d3_dig1}), 32'h4221);
    hold(8'hFD, 8'h25, 4);
    hold(8'hFB, 8'h25, 4);
    hold(8'hFB, 8'h01, 1);
    hold(8'hFB, 8'h25, 4);
    hold(8'hFB, 8'h01, 2);
    hold(8'hFB, 8'h25, 4);
    hold(8'hF7, 8'h99, 4);
    hold(8'hFE, 8'h9F, 4);
    checkOutput("d3_frame2", 32'(f3_cnt - b3), 32'd2);
    checkOutput("d3_dig100", 32'(d3_dig100), 32'd2);
    checkOutput("d3_dig2", 32'({d3_dig1000, d3_dig100, d3_dig10, d3_dig1}), 32'h4221);
    checkOutput("d3_flags", 32'({d3_valid, d3_code, d3_blank, d3_an, d3_stall}), 32'b10000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 250; n++) begin
      logic [7:0] a, s;
      int k, h, p, q;
      k = int'($urandom_range(0, 19));
      p = int'($urandom_range(0, 7));
      q = (p + 1 + int'($urandom_range(0, 6))) % 8;
      h = int'($urandom_range(1, 3));
      s = TB_CODES[$urandom_range(0, 15)];
      if (k < 12)       a = ~(8'h01 << (p % 4));
      else if (k < 14)  begin a = ~(8'h01 << (4 + p % 4)); s = ($urandom_range(0, 1) == 0) ? 8'hFF : s; end
      else if (k < 16)  begin a = ~(8'h01 << (p % 4)); s = 8'($urandom_range(0, 255)); end
      else if (k == 16) a = 8'hFF;
      else if (k == 17) a = ~((8'h01 << p) | (8'h01 << q));
      else              begin a = 8'hFE; h = 70; end
      applyStimulus(a, s, $urandom_range(0, 15) == 0);
      tick();
      clear_i = 1'b0;
      repeat (h - 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
